// File: rtl/dm_cache_tag_store.sv
// Direct-mapped cache tag/valid/dirty store with registered lookup, tag compare and
// an invalidate-all sweep after reset or flush. Define CACHE_TAG_PARITY_EN for per-entry parity.
module dm_cache_tag_store #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lk_valid,
  input  logic [INDEX_W-1:0] lk_index,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic               rsp_dirty,
  output logic [TAG_W-1:0]   rsp_tag,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  input  logic               flush_req,
  output logic               busy
`ifdef CACHE_TAG_PARITY_EN
  ,
  output logic               parity_err
`endif
);

  localparam int DEPTH = 2**INDEX_W;
`ifdef CACHE_TAG_PARITY_EN
  localparam int ENTRY_W = TAG_W + 3;
`else
  localparam int ENTRY_W = TAG_W + 2;
`endif

  typedef enum logic {ST_SWEEP, ST_IDLE} state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  // Entry layout: {[parity,] valid, dirty, tag}
  logic [ENTRY_W-1:0] tag_mem_q [DEPTH];
  logic [ENTRY_W-1:0] rd_q;
  logic [TAG_W-1:0]   lk_tag_q;
  logic               rsp_valid_q;

  logic               lk_accept;
  logic               mem_we;
  logic [INDEX_W-1:0] mem_waddr;
  logic [ENTRY_W-1:0] mem_wdata;
  logic [ENTRY_W-1:0] wr_entry;
  logic               tag_match;

`ifdef CACHE_TAG_PARITY_EN
  assign wr_entry = {^{wr_tag, wr_valid, wr_dirty}, wr_valid, wr_dirty, wr_tag};
`else
  assign wr_entry = {wr_valid, wr_dirty, wr_tag};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep owns the single write port; a user write shares it only while idle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_index;
    mem_wdata = wr_entry;
    case (state_q)
      ST_SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == {INDEX_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        mem_we = wr_en;
        if (flush_req) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy      = (state_q == ST_SWEEP);
  assign lk_accept = lk_valid && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      tag_mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read register loads only on an accepted lookup, so responses hold between lookups.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q        <= '0;
      lk_tag_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= lk_accept;
      if (lk_accept) begin
        rd_q     <= tag_mem_q[lk_index];
        lk_tag_q <= lk_tag;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tag   = rd_q[TAG_W-1:0];
  assign rsp_dirty = rd_q[TAG_W];
  assign tag_match = rd_q[TAG_W+1] && (rd_q[TAG_W-1:0] == lk_tag_q);

`ifdef CACHE_TAG_PARITY_EN
  assign parity_err = ^rd_q;
  assign rsp_hit    = tag_match && !parity_err;
`else
  assign rsp_hit    = tag_match;
`endif

endmodule
